// File: rtl/sam_dot_acc.sv
// Dot-product accumulator: sums a stream of signed 64-bit products into a wide
// accumulator and emits one saturated 64-bit result per vector.
module sam_dot_acc #(
  parameter int LEN   = 8,
  parameter int ACC_W = 72
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] product,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] sum,
  output logic        sat,
  output logic [8:0]  count
);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [8:0]         cnt_q, cnt_d;
  logic [63:0]        sum_q, sum_d;
  logic               sat_q, sat_d;
  logic [8:0]         count_q, count_d;

  logic [ACC_W-1:0]   acc_sum_s;
  logic               last_beat_s;
  logic [64:0]        clip_s;

  // Clip to the signed 64-bit range; bit 64 of the result is the overflow flag.
  // The value fits when every bit from 63 upward matches the sign.
  function automatic logic [64:0] sat64(input logic [ACC_W-1:0] s);
    logic [ACC_W-64:0] top;
    top = s[ACC_W-1:63];
    if ((&top) || (~|top)) begin
      return {1'b0, s[63:0]};
    end else if (s[ACC_W-1]) begin
      return {1'b1, 64'h8000_0000_0000_0000};
    end else begin
      return {1'b1, 64'h7FFF_FFFF_FFFF_FFFF};
    end
  endfunction

  // Running sum with the incoming product and its clipped form.
  always_comb begin
    acc_sum_s   = acc_q + {{(ACC_W-64){product[63]}}, product};
    last_beat_s = (cnt_q == 9'(LEN - 1)) || in_last;
    clip_s      = sat64(acc_sum_s);
  end

  // Next-state logic: accumulate in ACCUM, hold the result in DONE.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    sat_d   = sat_q;
    count_d = count_q;
    case (state_q)
      ST_ACCUM: begin
        if (in_valid) begin
          acc_d = acc_sum_s;
          cnt_d = cnt_q + 9'd1;
          if (last_beat_s) begin
            sum_d   = clip_s[63:0];
            sat_d   = clip_s[64];
            count_d = cnt_q + 9'd1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_ACCUM;
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          acc_d   = {ACC_W{1'b0}};
          cnt_d   = 9'd0;
          state_d = ST_ACCUM;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        acc_d   = {ACC_W{1'b0}};
        cnt_d   = 9'd0;
        state_d = ST_ACCUM;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      acc_q   <= {ACC_W{1'b0}};
      cnt_q   <= 9'd0;
      sum_q   <= 64'd0;
      sat_q   <= 1'b0;
      count_q <= 9'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      sat_q   <= sat_d;
      count_q <= count_d;
    end
  end

  // Handshakes are decoded purely from state, so no input-to-output paths.
  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign sat       = sat_q;
  assign count     = count_q;

endmodule

// File: tb/tb_sam_dot_acc.sv
// Directed self-checking bench for sam_dot_acc (LEN=8, ACC_W=72).
module tb_sam_dot_acc;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] product;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum;
  logic        sat;
  logic [8:0]  count;

  int n_assert;
  int n_fail;

  sam_dot_acc #(.LEN(8), .ACC_W(72)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .product   (product),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .sat       (sat),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [63:0] p, input logic last, input int gap);
    int t;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    product  = p;
    in_last  = last;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("send_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic chk_result(input string tag, input logic [63:0] es, input logic esat, input logic [8:0] ecnt);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_sum"},   sum,            es);
    chk({tag, "_sat"},   64'(sat),       64'(esat));
    chk({tag, "_count"}, 64'(count),     64'(ecnt));
  endtask

  initial begin
    logic [63:0] vec [8];
    n_assert  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    product   = 64'd0;
    out_ready = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum",       sum,            64'd0);
    chk("rst_sat",       64'(sat),       64'd0);
    chk("rst_count",     64'(count),     64'd0);

    // Full-length back-to-back vector: 1-2+3-4+5-6+7-8 = -4
    vec[0] = 64'd1;  vec[1] = -64'sd2; vec[2] = 64'd3;  vec[3] = -64'sd4;
    vec[4] = 64'd5;  vec[5] = -64'sd6; vec[6] = 64'd7;  vec[7] = -64'sd8;
    for (int i = 0; i < 8; i++) send(vec[i], 1'b0, 0);
    chk_result("full", 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 9'd8);
    chk("full_busy", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("full_ready_back", 64'(in_ready),  64'd1);
    chk("full_valid_drop", 64'(out_valid), 64'd0);

    // Early in_last with gaps, then a 5-cycle stall
    out_ready = 1'b0;
    send(64'h4000_0000_0000_0000, 1'b0, int'($urandom_range(0, 3)));
    send(64'h0000_0000_0000_0010, 1'b1, int'($urandom_range(0, 3)));
    chk_result("early", 64'h4000_0000_0000_0010, 1'b0, 9'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_ready", 64'(in_ready),  64'd0);
      chk("stall_sum",   sum,            64'h4000_0000_0000_0010);
      chk("stall_count", 64'(count),     64'd2);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_release", 64'(in_ready), 64'd1);

    // Positive saturation
    send(64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 0);
    send(64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 0);
    chk_result("pos_sat", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 9'd2);

    // Negative saturation (-2^63-1), then recovery
    send(64'h8000_0000_0000_0000, 1'b0, 0);
    send(64'h8000_0000_0000_0000, 1'b0, 0);
    send(64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 0);
    chk_result("neg_sat", 64'h8000_0000_0000_0000, 1'b1, 9'd3);
    send(64'd5, 1'b0, 0);
    send(64'd5, 1'b1, 0);
    chk_result("recover", 64'd10, 1'b0, 9'd2);

    // Reset mid-vector discards the partial 300
    for (int i = 0; i < 3; i++) send(64'd100, 1'b0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ready", 64'(in_ready),  64'd1);
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_sum",   sum,            64'd0);
    chk("midrst_count", 64'(count),     64'd0);
    for (int i = 0; i < 8; i++) send(64'd1, 1'b0, 0);
    chk_result("after_rst", 64'd8, 1'b0, 9'd8);

    // in_last on the LEN-th beat behaves as a normal final beat
    for (int i = 0; i < 8; i++) send(64'd2, (i == 7) ? 1'b1 : 1'b0, 0);
    chk_result("last_at_len", 64'd16, 1'b0, 9'd8);
    @(negedge clk);
    chk("final_idle", 64'(in_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
